// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the MIPS pipeline: datapath
//                widths, MEM-stage state encoding and the MEM/WB layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // Low address bits dropped to form a word address
   localparam int c_WORD_OFS_W = 2;

   // MEM-stage access sequencer states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic              regfile_write;
      logic              mem_to_reg;
      logic [DATA_W-1:0] read_data;
      logic [DATA_W-1:0] alu_result;
      logic [REG_W-1:0]  write_reg;
      logic              valid;
   } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_reg
//  Description : MEM/WB pipeline register. Loads a new entry when enabled,
//                clears to an empty entry on a bubble, otherwise holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg
   import mips_pkg::*;
(
   input  logic    clk,
   input  logic    rstn,      // asynchronous, active-high
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   mem_wb_t r_q;

   // Pipeline register: load wins over bubble; a bubble empties the entry
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d;
      end else if (bubble) begin
         r_q <= '0;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MIPS MEM stage. Issues one handshaked word access to the
//                data RAM per memory instruction, stalls upstream until the
//                RAM acknowledges, and feeds the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int REG_W  = mips_pkg::REG_W
) (
   input  logic              clk,
   input  logic              rstn,               // asynchronous, active-high
   input  logic              ivalid,
   input  logic              iSig_MemRead,
   input  logic              iSig_MemWrite,
   input  logic              iSig_regfile_write,
   input  logic              iSig_MemtoReg,
   input  logic [DATA_W-1:0] ialu_result,
   input  logic [DATA_W-1:0] istore_data,
   input  logic [REG_W-1:0]  iwrite_reg,
   output logic              ostall,
   output logic              omem_req,
   output logic              omem_we,
   output logic [DATA_W-1:0] omem_addr,
   output logic [DATA_W-1:0] omem_wdata,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              ovalid,
   output logic              oSig_regfile_write,
   output logic              oSig_MemtoReg,
   output logic [DATA_W-1:0] oread_from_ram,
   output logic [DATA_W-1:0] oalu_result,
   output logic [REG_W-1:0]  owrite_reg
);

   import mips_pkg::*;

   mem_state_t        r_state;
   mem_state_t        w_next_state;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              w_memop;
   logic              w_latch;
   logic              w_load;
   mem_wb_t           w_entry;
   mem_wb_t           w_wb;

   // A write takes priority when both read and write are flagged
   assign w_memop = ivalid & (iSig_MemRead | iSig_MemWrite);

   // Sequencer state register
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, stall/request and MEM/WB entry selection
   always_comb begin
      w_next_state          = r_state;
      w_latch               = 1'b0;
      w_load                = 1'b0;
      ostall                = 1'b0;
      omem_req              = 1'b0;
      w_entry               = '0;
      w_entry.regfile_write = iSig_regfile_write;
      w_entry.mem_to_reg    = iSig_MemtoReg;
      w_entry.alu_result    = ialu_result;
      w_entry.write_reg     = iwrite_reg;
      w_entry.valid         = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_memop) begin
               ostall       = 1'b1;
               w_latch      = 1'b1;
               w_next_state = BUSY;
            end else if (ivalid) begin
               w_load = 1'b1;
            end
         end
         BUSY: begin
            // Upstream still holds the instruction; it advances on the ack edge
            omem_req = 1'b1;
            ostall   = ~imem_ack;
            if (imem_ack) begin
               w_load       = 1'b1;
               w_next_state = IDLE;
               if (!r_we) begin
                  w_entry.read_data = imem_rdata;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // RAM request latch: captured once on entry to BUSY, stable while pending
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
      end else if (w_latch) begin
         r_addr  <= {ialu_result[DATA_W-1:c_WORD_OFS_W], {c_WORD_OFS_W{1'b0}}};
         r_wdata <= istore_data;
         r_we    <= iSig_MemWrite;
      end
   end

   assign omem_we    = r_we;
   assign omem_addr  = r_addr;
   assign omem_wdata = r_wdata;

   mem_wb_reg u_mem_wb_reg (
      .clk    (clk),
      .rstn   (rstn),
      .load   (w_load),
      .bubble (~w_load),
      .d      (w_entry),
      .q      (w_wb)
   );

   assign ovalid             = w_wb.valid;
   assign oSig_regfile_write = w_wb.regfile_write & w_wb.valid;
   assign oSig_MemtoReg      = w_wb.mem_to_reg;
   assign oread_from_ram     = w_wb.read_data;
   assign oalu_result        = w_wb.alu_result;
   assign owrite_reg         = w_wb.write_reg;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Self-checking bench for mem_access_stage. Stimulus pushes
//                expected RAM requests and MEM/WB entries into queues; monitors
//                pop and compare when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ivalid, iSig_MemRead, iSig_MemWrite, iSig_regfile_write, iSig_MemtoReg;
   logic [31:0] ialu_result, istore_data;
   logic [4:0]  iwrite_reg;
   logic        ostall, omem_req, omem_we;
   logic [31:0] omem_addr, omem_wdata;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ovalid, oSig_regfile_write, oSig_MemtoReg;
   logic [31:0] oread_from_ram, oalu_result;
   logic [4:0]  owrite_reg;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .ivalid             (ivalid),
      .iSig_MemRead       (iSig_MemRead),
      .iSig_MemWrite      (iSig_MemWrite),
      .iSig_regfile_write (iSig_regfile_write),
      .iSig_MemtoReg      (iSig_MemtoReg),
      .ialu_result        (ialu_result),
      .istore_data        (istore_data),
      .iwrite_reg         (iwrite_reg),
      .ostall             (ostall),
      .omem_req           (omem_req),
      .omem_we            (omem_we),
      .omem_addr          (omem_addr),
      .omem_wdata         (omem_wdata),
      .imem_ack           (imem_ack),
      .imem_rdata         (imem_rdata),
      .ovalid             (ovalid),
      .oSig_regfile_write (oSig_regfile_write),
      .oSig_MemtoReg      (oSig_MemtoReg),
      .oread_from_ram     (oread_from_ram),
      .oalu_result        (oalu_result),
      .owrite_reg         (owrite_reg)
   );

   typedef struct {
      logic        rfw;
      logic        m2r;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  wr;
   } wb_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          len;     // expected request cycles; negative = not checked
   } req_exp_t;

   wb_exp_t  wb_q[$];
   req_exp_t req_q[$];
   int       rise_cycle[$];
   int       n_cmp = 0;
   int       n_err = 0;
   int       cycle = 0;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM model: mode 0 acks in the ram_lat-th request cycle, mode 1 never
   // acks, mode 2 holds ack high regardless of any request
   int          ram_mode  = 0;
   int          ram_lat   = 1;
   logic [31:0] ram_rdata = '0;
   int          req_cnt   = 0;
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hFFFF_FFFF;
      forever begin
         @(negedge clk);
         #1;
         if (ram_mode == 2) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h5A5A_5A5A;
         end else if (omem_req && ram_mode == 0) begin
            req_cnt++;
            imem_ack   = (req_cnt == ram_lat);
            imem_rdata = imem_ack ? ram_rdata : 32'hFFFF_FFFF;
         end else begin
            req_cnt    = 0;
            imem_ack   = 1'b0;
            imem_rdata = 32'hFFFF_FFFF;
         end
      end
   end

   // MEM/WB monitor
   wb_exp_t mon_e;
   always @(negedge clk) begin
      if (!rstn && ovalid) begin
         if (wb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected: got entry alu=0x%08h, expected no entry", oalu_result);
         end else begin
            mon_e = wb_q.pop_front();
            check("wb_regfile_write", 32'(oSig_regfile_write), 32'(mon_e.rfw));
            check("wb_memtoreg",      32'(oSig_MemtoReg),      32'(mon_e.m2r));
            check("wb_read_data",     oread_from_ram,          mon_e.rdata);
            check("wb_alu_result",    oalu_result,             mon_e.alu);
            check("wb_write_reg",     32'(owrite_reg),         32'(mon_e.wr));
         end
      end
   end

   // RAM request monitor
   logic     req_prev = 1'b0;
   int       req_len  = 0;
   req_exp_t cur_req;
   always @(negedge clk) begin
      if (omem_req && !req_prev) begin
         rise_cycle.push_back(cycle);
         req_len = 0;
         if (req_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_unexpected: got request addr=0x%08h, expected none", omem_addr);
            cur_req = '{addr: '0, we: 1'b0, wdata: '0, len: -1};
         end else begin
            cur_req = req_q.pop_front();
            check("req_addr", omem_addr, cur_req.addr);
            check("req_we", 32'(omem_we), 32'(cur_req.we));
            if (cur_req.we) check("req_wdata", omem_wdata, cur_req.wdata);
         end
      end
      if (omem_req) req_len++;
      if (!omem_req && req_prev && cur_req.len >= 0)
         check("req_len", 32'(req_len), 32'(cur_req.len));
      req_prev = omem_req;
   end

   // Present one instruction and hold it until the stage stops stalling
   task automatic step(input logic v, input logic rd, input logic wr, input logic rfw,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wreg, input int lat, input logic [31:0] rdat,
                       input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
      int   stalls = 0;
      logic memop  = v & (rd | wr);
      bit   done   = 0;
      @(negedge clk);
      #2;
      ram_lat            = lat;
      ram_rdata          = rdat;
      ivalid             = v;
      iSig_MemRead       = rd;
      iSig_MemWrite      = wr;
      iSig_regfile_write = rfw;
      iSig_MemtoReg      = m2r;
      ialu_result        = alu;
      istore_data        = sd;
      iwrite_reg         = wreg;
      if (memop) req_q.push_back('{addr: exp_addr, we: wr, wdata: sd, len: lat});
      if (v) wb_q.push_back('{rfw: rfw, m2r: m2r, rdata: exp_rdata, alu: alu, wr: wreg});
      for (int n = 0; n < 64; n++) begin
         #1;
         if (!ostall) begin
            done = 1;
            break;
         end
         stalls++;
         @(negedge clk);
         #2;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL stall_timeout: got ostall stuck at 1, expected release within 64 cycles");
      end else if (v) begin
         check("stall_cycles", 32'(stalls), memop ? 32'(lat) : 32'd0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      rstn = 1'b1;
      ivalid = 0; iSig_MemRead = 0; iSig_MemWrite = 0; iSig_regfile_write = 0;
      iSig_MemtoReg = 0; ialu_result = '0; istore_data = '0; iwrite_reg = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ostall",   32'(ostall),             32'd0);
      check("rst_req",      32'(omem_req),           32'd0);
      check("rst_we",       32'(omem_we),            32'd0);
      check("rst_addr",     omem_addr,               32'd0);
      check("rst_wdata",    omem_wdata,              32'd0);
      check("rst_ovalid",   32'(ovalid),             32'd0);
      check("rst_rfw",      32'(oSig_regfile_write), 32'd0);
      check("rst_rdata",    oread_from_ram,          32'd0);
      #1;
      rstn = 1'b0;

      // ALU-only op
      step(1, 0, 0, 1, 0, 32'h0000_002A, 32'h0, 5'd5, 1, 32'h0, 32'h0, 32'h0);
      // Load, 3-cycle latency, unaligned address
      step(1, 1, 0, 1, 1, 32'h0000_0103, 32'hAAAA_5555, 5'd8, 3, 32'hDEAD_BEEF,
           32'h0000_0100, 32'hDEAD_BEEF);
      // Store, ack in first BUSY cycle; RAM drives junk read data on the ack
      step(1, 0, 1, 0, 0, 32'h0000_0204, 32'h1234_5678, 5'd0, 1, 32'hCAFE_F00D,
           32'h0000_0204, 32'h0);
      // Read and write both flagged: treated as a write
      step(1, 1, 1, 0, 0, 32'h0000_0307, 32'h0BAD_F00D, 5'd3, 2, 32'h5555_5555,
           32'h0000_0304, 32'h0);
      // Bubble with regfile_write asserted on the inputs
      step(0, 0, 0, 1, 0, 32'h0000_0099, 32'h0, 5'd9, 1, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check("bubble_ovalid", 32'(ovalid),             32'd0);
      check("bubble_rfw",    32'(oSig_regfile_write), 32'd0);

      // Back-to-back loads with immediate ack, then an ALU op
      r0 = rise_cycle.size();
      step(1, 1, 0, 1, 1, 32'h0000_0010, 32'h0, 5'd1, 1, 32'h1111_1111,
           32'h0000_0010, 32'h1111_1111);
      step(1, 1, 0, 1, 1, 32'h0000_0016, 32'h0, 5'd2, 1, 32'h2222_2222,
           32'h0000_0014, 32'h2222_2222);
      step(1, 0, 0, 1, 0, 32'h0000_0007, 32'h0, 5'd7, 1, 32'h0, 32'h0, 32'h0);
      idle(2);
      if (rise_cycle.size() >= r0 + 2)
         check("b2b_req_spacing", 32'(rise_cycle[r0+1] - rise_cycle[r0]), 32'd2);
      else
         check("b2b_req_count", 32'(rise_cycle.size() - r0), 32'd2);

      // Reset while an access is pending
      ram_mode = 1;
      @(negedge clk);
      #2;
      ivalid = 1; iSig_MemRead = 1; iSig_MemWrite = 0; iSig_regfile_write = 1;
      iSig_MemtoReg = 1; ialu_result = 32'h0000_0400; iwrite_reg = 5'd4;
      req_q.push_back('{addr: 32'h0000_0400, we: 1'b0, wdata: '0, len: -1});
      repeat (3) @(negedge clk);
      #4;
      check("busy_req_before_rst", 32'(omem_req), 32'd1);
      rstn = 1'b1;
      #1;
      check("abort_req",    32'(omem_req), 32'd0);
      check("abort_ovalid", 32'(ovalid),   32'd0);
      ivalid = 0; iSig_MemRead = 0; iSig_regfile_write = 0; iSig_MemtoReg = 0;
      @(negedge clk);
      #2;
      rstn     = 1'b0;
      ram_mode = 2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #3;
         check("late_ack_req",    32'(omem_req), 32'd0);
         check("late_ack_ovalid", 32'(ovalid),   32'd0);
      end
      ram_mode = 0;
      @(negedge clk);

      // Recovery after reset, all-ones boundary values
      step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1, 32'h0, 32'h0, 32'h0);
      idle(3);

      check("wb_queue_drained",  32'(wb_q.size()),  32'd0);
      check("req_queue_drained", 32'(req_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
